// File: rtl/fwd_pkg.sv
// Shared definitions for the EX-stage operand-forwarding / load-use hazard block:
// mux select encodings, the hazard FSM state type and the pipeline shadow entry.
package fwd_pkg;

    // Operand mux selects seen by the EX-stage ALU
    localparam logic [1:0] FWD_RF = 2'b00;  // register-file operand
    localparam logic [1:0] FWD_WB = 2'b01;  // MEM/WB writeback value
    localparam logic [1:0] FWD_EX = 2'b10;  // EX/MEM ALU result

    // Shadow rd field is sized for the widest register index we support;
    // narrower indices are zero-extended into it (REG_ADDR_W must be <= 8).
    localparam int SHADOW_RD_W = 8;

    // Load-use stall counter; STALL_CYCLES is limited to 1..3
    localparam int CNT_W = 2;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } fwd_state_e;

    typedef struct packed {
        logic                   valid;
        logic [SHADOW_RD_W-1:0] rd;
        logic                   reg_write;
        logic                   mem_read;
    } shadow_entry_t;

endpackage

// File: rtl/fwd_sel_logic.sv
// Forwarding select for one source operand: compares rs against the rd of the
// instruction about to enter MEM (ID/EX shadow) and the one about to enter WB
// (EX/MEM shadow). The nearer producer wins; x0 never forwards.
module fwd_sel_logic
    import fwd_pkg::*;
(
    input  logic [SHADOW_RD_W-1:0] rs,
    input  logic                   slot_valid,
    input  shadow_entry_t          idex,
    input  shadow_entry_t          exmem,
    output logic [1:0]             sel
);

    // Priority encode: youngest producer first, then the older one
    always_comb begin
        sel = FWD_RF;
        if (slot_valid && (rs != '0)) begin
            if (idex.valid && idex.reg_write && (idex.rd == rs)) begin
                sel = FWD_EX;
            end else if (exmem.valid && exmem.reg_write && (exmem.rd == rs)) begin
                sel = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Operand-forwarding select generation and load-use hazard control for the
// EX stage of the 5-stage pipeline. Keeps destination-register shadows for
// ID/EX, EX/MEM and MEM/WB, registers the mux selects for the EX cycle and
// stalls IF/ID while injecting ID/EX bubbles on a load-use dependency.
// Optional build macro FWD_STATS_EN adds saturating forward/stall counters.
module fwd_hazard_ctrl
    import fwd_pkg::*;
#(
    parameter int REG_ADDR_W   = 5,
    parameter int STALL_CYCLES = 1
`ifdef FWD_STATS_EN
   ,parameter int STATS_W      = 32
`endif
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  hold,
    input  logic                  flush,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel,
    output logic                  stall_if_id,
    output logic                  bubble_id_ex
`ifdef FWD_STATS_EN
   ,output logic [STATS_W-1:0]    stat_fwd_ex,
    output logic [STATS_W-1:0]    stat_fwd_wb,
    output logic [STATS_W-1:0]    stat_stall_cycles
`endif
);

    shadow_entry_t          idex_q, idex_d;
    shadow_entry_t          exmem_q, exmem_d;
    shadow_entry_t          memwb_q, memwb_d;
    logic [1:0]             sel_a_q, sel_a_d, sel_b_q, sel_b_d;
    logic [1:0]             sel_a_c, sel_b_c;
    fwd_state_e             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [SHADOW_RD_W-1:0] rs1_x, rs2_x, rd_x;
    logic                   load_use;
    logic                   kill;

    assign rs1_x = SHADOW_RD_W'(id_rs1);
    assign rs2_x = SHADOW_RD_W'(id_rs2);
    assign rd_x  = SHADOW_RD_W'(id_rd);

    fwd_sel_logic u_sel_a (
        .rs         (rs1_x),
        .slot_valid (id_valid),
        .idex       (idex_q),
        .exmem      (exmem_q),
        .sel        (sel_a_c)
    );

    fwd_sel_logic u_sel_b (
        .rs         (rs2_x),
        .slot_valid (id_valid),
        .idex       (idex_q),
        .exmem      (exmem_q),
        .sel        (sel_b_c)
    );

    // The load sitting in ID/EX cannot forward its data to the very next instruction
    assign load_use = id_valid && idex_q.valid && idex_q.mem_read && (idex_q.rd != '0) &&
                      ((idex_q.rd == rs1_x) || (idex_q.rd == rs2_x));

    // Hazard FSM, stall/bubble outputs and shadow/select advance
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        stall_if_id  = 1'b0;
        bubble_id_ex = 1'b0;
        idex_d       = idex_q;
        exmem_d      = exmem_q;
        memwb_d      = memwb_q;
        sel_a_d      = sel_a_q;
        sel_b_d      = sel_b_q;
        kill         = 1'b0;

        case (state_q)
            RUN: begin
                if (load_use) begin
                    stall_if_id  = 1'b1;
                    bubble_id_ex = 1'b1;
                    // A single-bubble stall finishes this cycle and stays in RUN
                    if (STALL_CYCLES > 1) begin
                        cnt_d   = CNT_W'(STALL_CYCLES - 1);
                        state_d = STALL;
                    end
                end
            end
            STALL: begin
                stall_if_id  = 1'b1;
                bubble_id_ex = 1'b1;
                cnt_d        = cnt_q - 1'b1;
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase

        if (hold) begin
            // Frozen pipeline: state and inputs are stable, so stall/bubble keep their level
            state_d = state_q;
            cnt_d   = cnt_q;
        end else begin
            if (flush) begin
                // Redirect wins over the stall; the stalled consumer is being killed anyway
                state_d      = RUN;
                cnt_d        = '0;
                stall_if_id  = 1'b0;
                bubble_id_ex = 1'b0;
            end
            kill    = bubble_id_ex || flush;
            memwb_d = exmem_q;
            exmem_d = idex_q;
            if (kill || !id_valid) begin
                idex_d = '0;
            end else begin
                idex_d = '{valid: 1'b1, rd: rd_x, reg_write: id_reg_write, mem_read: id_mem_read};
            end
            sel_a_d = kill ? FWD_RF : sel_a_c;
            sel_b_d = kill ? FWD_RF : sel_b_c;
        end
    end

    // State registers; reset leaves empty shadows so nothing forwards afterwards
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
            idex_q  <= '0;
            exmem_q <= '0;
            memwb_q <= '0;
            sel_a_q <= FWD_RF;
            sel_b_q <= FWD_RF;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idex_q  <= idex_d;
            exmem_q <= exmem_d;
            memwb_q <= memwb_d;
            sel_a_q <= sel_a_d;
            sel_b_q <= sel_b_d;
        end
    end

    assign fwd_a_sel = sel_a_q;
    assign fwd_b_sel = sel_b_q;

`ifdef FWD_STATS_EN
    logic [STATS_W-1:0] st_ex_q, st_ex_d;
    logic [STATS_W-1:0] st_wb_q, st_wb_d;
    logic [STATS_W-1:0] st_stall_q, st_stall_d;

    function automatic logic [STATS_W-1:0] sat_add(input logic [STATS_W-1:0] a,
                                                   input logic [1:0]         inc);
        logic [STATS_W:0] s;
        s = {1'b0, a} + {{(STATS_W-1){1'b0}}, inc};
        return s[STATS_W] ? '1 : s[STATS_W-1:0];
    endfunction

    // Count selects as they are registered, and every non-frozen stall cycle
    always_comb begin
        st_ex_d    = st_ex_q;
        st_wb_d    = st_wb_q;
        st_stall_d = st_stall_q;
        if (!hold) begin
            st_ex_d    = sat_add(st_ex_q, {1'b0, sel_a_d == FWD_EX} + {1'b0, sel_b_d == FWD_EX});
            st_wb_d    = sat_add(st_wb_q, {1'b0, sel_a_d == FWD_WB} + {1'b0, sel_b_d == FWD_WB});
            st_stall_d = sat_add(st_stall_q, {1'b0, stall_if_id});
        end
    end

    // Statistics registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st_ex_q    <= '0;
            st_wb_q    <= '0;
            st_stall_q <= '0;
        end else begin
            st_ex_q    <= st_ex_d;
            st_wb_q    <= st_wb_d;
            st_stall_q <= st_stall_d;
        end
    end

    assign stat_fwd_ex       = st_ex_q;
    assign stat_fwd_wb       = st_wb_q;
    assign stat_stall_cycles = st_stall_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl: a vector table replayed as one
// instruction stream, plus hand sequences for multi-cycle stall, hold and reset.
module tb_fwd_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       hold = 1'b0;
    logic       flush = 1'b0;
    logic       id_valid = 1'b0;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic       id_reg_write = 1'b0, id_mem_read = 1'b0;

    logic [1:0] a1, b1, a3, b3;
    logic       st1, bb1, st3, bb3;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fwd_hazard_ctrl #(.REG_ADDR_W(5), .STALL_CYCLES(1)) dut (
        .clk(clk), .reset_n(reset_n), .hold(hold), .flush(flush),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .fwd_a_sel(a1), .fwd_b_sel(b1), .stall_if_id(st1), .bubble_id_ex(bb1)
    );

    fwd_hazard_ctrl #(.REG_ADDR_W(5), .STALL_CYCLES(3)) dut3 (
        .clk(clk), .reset_n(reset_n), .hold(hold), .flush(flush),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .fwd_a_sel(a3), .fwd_b_sel(b3), .stall_if_id(st3), .bubble_id_ex(bb3)
    );

    typedef struct {
        logic       fl;
        logic       v;
        logic [4:0] rs1, rs2, rd;
        logic       rw, mr;
        logic [1:0] ea, eb;
        logic       est, ebb;
    } vec_t;

    vec_t tbl[27];

    function automatic vec_t mk(input logic fl, input logic v, input int rs1, input int rs2,
                                input int rd, input logic rw, input logic mr,
                                input int ea, input int eb, input logic est, input logic ebb);
        vec_t r;
        r.fl = fl; r.v = v;
        r.rs1 = 5'(rs1); r.rs2 = 5'(rs2); r.rd = 5'(rd);
        r.rw = rw; r.mr = mr;
        r.ea = 2'(ea); r.eb = 2'(eb);
        r.est = est; r.ebb = ebb;
        return r;
    endfunction

    task automatic chk(input string name, input int idx, input logic [1:0] act, input logic [1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %b expected %b", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic h, input logic fl, input logic v, input int rs1, input int rs2,
                         input int rd, input logic rw, input logic mr);
        hold = h; flush = fl; id_valid = v;
        id_rs1 = 5'(rs1); id_rs2 = 5'(rs2); id_rd = 5'(rd);
        id_reg_write = rw; id_mem_read = mr;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        next_cycle();
    endtask

    initial begin
        // inputs: fl, v, rs1, rs2, rd, rw, mr ; expected: a, b, stall, bubble
        tbl[0]  = mk(0, 1,  1,  2,  5, 1, 0, 0, 0, 0, 0); // add x5,x1,x2
        tbl[1]  = mk(0, 1,  5,  3,  6, 1, 0, 0, 0, 0, 0); // add x6,x5,x3
        tbl[2]  = mk(0, 0,  0,  0,  0, 0, 0, 2, 0, 0, 0); // x6 in EX: a=EX
        tbl[3]  = mk(0, 1,  1,  2,  5, 1, 0, 0, 0, 0, 0); // add x5
        tbl[4]  = mk(0, 0,  0,  0,  0, 0, 0, 0, 0, 0, 0); // nop
        tbl[5]  = mk(0, 1,  4,  5,  7, 1, 0, 0, 0, 0, 0); // sub x7,x4,x5
        tbl[6]  = mk(0, 0,  0,  0,  0, 0, 0, 0, 1, 0, 0); // b=WB
        tbl[7]  = mk(0, 1,  1,  2,  5, 1, 0, 0, 0, 0, 0); // add x5
        tbl[8]  = mk(0, 1,  3,  4,  5, 1, 0, 0, 0, 0, 0); // add x5 again
        tbl[9]  = mk(0, 1,  5,  5,  8, 1, 0, 0, 0, 0, 0); // or x8,x5,x5
        tbl[10] = mk(0, 0,  0,  0,  0, 0, 0, 2, 2, 0, 0); // nearer producer wins
        tbl[11] = mk(0, 1,  2,  0,  9, 1, 1, 0, 0, 0, 0); // ld x9
        tbl[12] = mk(0, 1,  9,  9, 10, 1, 0, 0, 0, 1, 1); // add x10,x9,x9: stall
        tbl[13] = mk(0, 1,  9,  9, 10, 1, 0, 0, 0, 0, 0); // re-presented, released
        tbl[14] = mk(0, 0,  0,  0,  0, 0, 0, 1, 1, 0, 0); // both from WB
        tbl[15] = mk(0, 1,  1,  2,  0, 1, 0, 0, 0, 0, 0); // add x0
        tbl[16] = mk(0, 1,  0,  0, 11, 1, 0, 0, 0, 0, 0); // add x11,x0,x0
        tbl[17] = mk(0, 1,  3,  0,  0, 1, 1, 0, 0, 0, 0); // ld x0
        tbl[18] = mk(0, 1,  0,  0, 12, 1, 0, 0, 0, 0, 0); // reader of x0: no stall
        tbl[19] = mk(0, 0,  0,  0,  0, 0, 0, 0, 0, 0, 0);
        tbl[20] = mk(0, 1,  1,  1, 13, 1, 0, 0, 0, 0, 0); // add x13
        tbl[21] = mk(0, 0, 13, 13,  0, 0, 0, 0, 0, 0, 0); // invalid slot reading x13
        tbl[22] = mk(0, 0,  0,  0,  0, 0, 0, 0, 0, 0, 0); // invalid -> 00
        tbl[23] = mk(0, 1,  1,  0,  9, 1, 1, 0, 0, 0, 0); // ld x9
        tbl[24] = mk(1, 1,  9,  9, 14, 1, 0, 0, 0, 0, 0); // load-use under flush
        tbl[25] = mk(0, 1, 14,  1, 15, 1, 0, 0, 0, 0, 0); // new path reads x14
        tbl[26] = mk(0, 0,  0,  0,  0, 0, 0, 0, 0, 0, 0); // killed x14 not forwarded

        // reset state, checked while reset is held
        #2;
        chk("rst_a", 0, a1, 2'b00);
        chk("rst_b", 0, b1, 2'b00);
        chk("rst_stall", 0, {1'b0, st1}, 2'b00);
        chk("rst_bubble", 0, {1'b0, bb1}, 2'b00);
        do_reset();

        for (int i = 0; i < 27; i++) begin
            drive(0, tbl[i].fl, tbl[i].v, int'(tbl[i].rs1), int'(tbl[i].rs2), int'(tbl[i].rd),
                  tbl[i].rw, tbl[i].mr);
            @(negedge clk);
            chk("tbl_a", i, a1, tbl[i].ea);
            chk("tbl_b", i, b1, tbl[i].eb);
            chk("tbl_stall", i, {1'b0, st1}, {1'b0, tbl[i].est});
            chk("tbl_bubble", i, {1'b0, bb1}, {1'b0, tbl[i].ebb});
            next_cycle();
        end

        // three-bubble load-use on the STALL_CYCLES=3 instance
        do_reset();
        drive(0, 0, 1, 1, 0, 9, 1, 1);          // ld x9
        @(negedge clk); chk("s3_stall", 0, {1'b0, st3}, 2'b00);
        next_cycle();
        for (int c = 1; c <= 4; c++) begin
            drive(0, 0, 1, 9, 9, 10, 1, 0);     // add x10,x9,x9 held in decode
            @(negedge clk);
            chk("s3_stall", c, {1'b0, st3}, (c <= 3) ? 2'b01 : 2'b00);
            chk("s3_bubble", c, {1'b0, bb3}, (c <= 3) ? 2'b01 : 2'b00);
            next_cycle();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("s3_a", 5, a3, 2'b00);
        chk("s3_b", 5, b3, 2'b00);
        next_cycle();

        // hold for 4 cycles in the middle of the 3-cycle stall (flush ignored while held)
        do_reset();
        drive(0, 0, 1, 1, 0, 9, 1, 1);          // ld x9
        next_cycle();
        drive(0, 0, 1, 9, 9, 10, 1, 0);         // stall cycle 1
        @(negedge clk); chk("h_stall3", 1, {1'b0, st3}, 2'b01);
        next_cycle();
        for (int c = 2; c <= 5; c++) begin
            drive(1, (c == 4), 1, 9, 9, 10, 1, 0);
            @(negedge clk);
            chk("h_stall3", c, {1'b0, st3}, 2'b01);
            chk("h_bubble3", c, {1'b0, bb3}, 2'b01);
            chk("h_stall1", c, {1'b0, st1}, 2'b00);
            chk("h_a1", c, a1, 2'b00);
            next_cycle();
        end
        for (int c = 6; c <= 8; c++) begin
            drive(0, 0, 1, 9, 9, 10, 1, 0);
            @(negedge clk);
            chk("h_stall3", c, {1'b0, st3}, (c <= 7) ? 2'b01 : 2'b00);
            if (c == 7) begin
                // load stayed in EX/MEM through the hold, so it now forwards from WB
                chk("h_a1", c, a1, 2'b01);
                chk("h_b1", c, b1, 2'b01);
            end
            next_cycle();
        end

        // hold freezes a nonzero registered select
        do_reset();
        drive(0, 0, 1, 1, 2, 5, 1, 0);          // add x5
        next_cycle();
        drive(0, 0, 1, 5, 5, 6, 1, 0);          // add x6,x5,x5
        next_cycle();
        for (int c = 0; c < 3; c++) begin
            drive((c < 2), 0, 0, 0, 0, 0, 0, 0);
            @(negedge clk);
            chk("hs_a", c, a1, 2'b10);
            chk("hs_b", c, b1, 2'b10);
            next_cycle();
        end
        @(negedge clk);
        chk("hs_a", 3, a1, 2'b00);
        next_cycle();

        // reset asserted mid-stall: back in RUN with empty shadows
        do_reset();
        drive(0, 0, 1, 1, 0, 9, 1, 1);          // ld x9
        next_cycle();
        drive(0, 0, 1, 9, 9, 10, 1, 0);
        @(negedge clk); chk("r_stall3", 0, {1'b0, st3}, 2'b01);
        next_cycle();
        #1 reset_n = 1'b0;
        @(negedge clk);
        chk("r_stall3", 1, {1'b0, st3}, 2'b00);
        #1 reset_n = 1'b1;
        next_cycle();
        @(negedge clk);
        chk("r_stall3", 2, {1'b0, st3}, 2'b00);
        chk("r_a3", 2, a3, 2'b00);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("r_a3", 3, a3, 2'b00);
        chk("r_b3", 3, b3, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
